// File: rtl/wdt_ctrl.sv
// Watchdog controller: prescaled timeout counter with a keyed kick, an
// early-warning stage (WARN_PEND / IRQ) and a fixed-width active-low reset
// pulse on the second expiry. Only the external reset i_rst clears it, so
// configuration and cause flags survive the internal resets it requests.
module wdt_ctrl #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned PRESC_W   = 8,
  parameter int unsigned RST_PULSE = 4,
  parameter logic [31:0] KICK_KEY  = 32'h5A5A_A5A5,
  parameter logic [31:0] RST_LOAD  = 32'h0000_FFFF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_halt,
  input  logic        i_we,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_irq,
  output logic        o_rst_wdt
);

  localparam int unsigned PW = $clog2(RST_PULSE + 1);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_LOAD   = 2'd1;
  localparam logic [1:0] ADDR_KICK   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WARN = 2'd2,
    BITE = 2'd3
  } state_t;

  // Registered state
  state_t               state_r;
  logic                 ctrl_en_r;
  logic                 ctrl_irq_en_r;
  logic                 ctrl_lock_r;
  logic [PRESC_W-1:0]   ctrl_presc_r;
  logic [CNT_W-1:0]     load_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [PRESC_W-1:0]   presc_cnt_r;
  logic [PW-1:0]        pulse_cnt_r;
  logic                 warn_pend_r;
  logic                 bitten_r;
  logic                 irq_r;
  logic                 rst_wdt_r;

  // Decoded events and next values
  logic                 wr_ctrl_s;
  logic                 wr_load_s;
  logic                 wr_status_s;
  logic                 kick_s;
  logic                 counting_s;
  logic                 tick_s;
  logic                 expire_s;
  logic                 en_nxt_s;
  logic                 irq_en_nxt_s;
  logic                 lock_nxt_s;
  logic [PRESC_W-1:0]   presc_nxt_s;
  logic                 warn_set_s;
  logic                 bite_set_s;
  logic                 warn_pend_nxt_s;
  logic                 bitten_nxt_s;
  logic                 busy_s;

  // Decode register writes, kick, prescaler tick, expiry and flag updates
  always_comb begin
    wr_ctrl_s   = i_we && (i_addr == ADDR_CTRL) && !ctrl_lock_r;
    wr_load_s   = i_we && (i_addr == ADDR_LOAD) && !ctrl_lock_r;
    wr_status_s = i_we && (i_addr == ADDR_STATUS);
    kick_s      = i_we && (i_addr == ADDR_KICK) && (i_wdata == KICK_KEY) &&
                  ctrl_en_r && ((state_r == RUN) || (state_r == WARN));
    counting_s  = ((state_r == RUN) || (state_r == WARN)) && !i_halt;
    tick_s      = counting_s && (presc_cnt_r == ctrl_presc_r);
    expire_s    = tick_s && (cnt_r == {CNT_W{1'b0}});
    busy_s      = (state_r != IDLE);

    if (wr_ctrl_s) begin
      en_nxt_s     = i_wdata[0];
      irq_en_nxt_s = i_wdata[1];
      lock_nxt_s   = i_wdata[2];
      presc_nxt_s  = i_wdata[8 +: PRESC_W];
    end else begin
      en_nxt_s     = ctrl_en_r;
      irq_en_nxt_s = ctrl_irq_en_r;
      lock_nxt_s   = ctrl_lock_r;
      presc_nxt_s  = ctrl_presc_r;
    end

    // A kick in the expiry cycle wins; disabling wins over both.
    warn_set_s = (state_r == RUN)  && en_nxt_s && !kick_s && expire_s;
    bite_set_s = (state_r == WARN) && en_nxt_s && !kick_s && expire_s;

    // Set has priority over a simultaneous write-1-clear.
    warn_pend_nxt_s = warn_set_s || (warn_pend_r && !(wr_status_s && i_wdata[0]));
    bitten_nxt_s    = bite_set_s || (bitten_r && !(wr_status_s && i_wdata[1]));
  end

  // Combinational register readback at i_addr
  always_comb begin
    o_rdata = 32'd0;
    case (i_addr)
      ADDR_CTRL: begin
        o_rdata[0]             = ctrl_en_r;
        o_rdata[1]             = ctrl_irq_en_r;
        o_rdata[2]             = ctrl_lock_r;
        o_rdata[8 +: PRESC_W]  = ctrl_presc_r;
      end
      ADDR_LOAD: begin
        o_rdata = 32'(load_r);
      end
      ADDR_KICK: begin
        o_rdata = 32'd0;
      end
      ADDR_STATUS: begin
        o_rdata[0]     = warn_pend_r;
        o_rdata[1]     = bitten_r;
        o_rdata[2]     = busy_s;
        o_rdata[31:16] = 16'(cnt_r);
      end
      default: begin
        o_rdata = 32'd0;
      end
    endcase
  end

  // Configuration, status flags, watchdog FSM with counter/prescaler and outputs
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r       <= IDLE;
      ctrl_en_r     <= 1'b0;
      ctrl_irq_en_r <= 1'b0;
      ctrl_lock_r   <= 1'b0;
      ctrl_presc_r  <= {PRESC_W{1'b0}};
      load_r        <= CNT_W'(RST_LOAD);
      cnt_r         <= CNT_W'(RST_LOAD);
      presc_cnt_r   <= {PRESC_W{1'b0}};
      pulse_cnt_r   <= {PW{1'b0}};
      warn_pend_r   <= 1'b0;
      bitten_r      <= 1'b0;
      irq_r         <= 1'b0;
      rst_wdt_r     <= 1'b1;
    end else begin
      ctrl_en_r     <= en_nxt_s;
      ctrl_irq_en_r <= irq_en_nxt_s;
      ctrl_lock_r   <= lock_nxt_s;
      ctrl_presc_r  <= presc_nxt_s;
      if (wr_load_s) begin
        load_r <= i_wdata[CNT_W-1:0];
      end else begin
        load_r <= load_r;
      end
      warn_pend_r <= warn_pend_nxt_s;
      bitten_r    <= bitten_nxt_s;
      irq_r       <= warn_pend_nxt_s && irq_en_nxt_s;

      case (state_r)
        IDLE: begin
          cnt_r       <= load_r;
          presc_cnt_r <= {PRESC_W{1'b0}};
          pulse_cnt_r <= {PW{1'b0}};
          rst_wdt_r   <= 1'b1;
          if (en_nxt_s) begin
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end

        RUN, WARN: begin
          pulse_cnt_r <= {PW{1'b0}};
          if (!en_nxt_s) begin
            state_r     <= IDLE;
            cnt_r       <= load_r;
            presc_cnt_r <= {PRESC_W{1'b0}};
            rst_wdt_r   <= 1'b1;
          end else if (kick_s) begin
            state_r     <= RUN;
            cnt_r       <= load_r;
            presc_cnt_r <= {PRESC_W{1'b0}};
            rst_wdt_r   <= 1'b1;
          end else if (expire_s) begin
            // First expiry warns, second one bites.
            state_r     <= (state_r == RUN) ? WARN : BITE;
            cnt_r       <= load_r;
            presc_cnt_r <= {PRESC_W{1'b0}};
            rst_wdt_r   <= (state_r == RUN);
          end else if (tick_s) begin
            state_r     <= state_r;
            cnt_r       <= cnt_r - CNT_W'(1);
            presc_cnt_r <= {PRESC_W{1'b0}};
            rst_wdt_r   <= 1'b1;
          end else if (counting_s) begin
            state_r     <= state_r;
            cnt_r       <= cnt_r;
            presc_cnt_r <= presc_cnt_r + PRESC_W'(1);
            rst_wdt_r   <= 1'b1;
          end else begin
            state_r     <= state_r;
            cnt_r       <= cnt_r;
            presc_cnt_r <= presc_cnt_r;
            rst_wdt_r   <= 1'b1;
          end
        end

        BITE: begin
          // Pulse runs to completion regardless of kicks, EN or halt.
          if (pulse_cnt_r == PW'(RST_PULSE - 1)) begin
            rst_wdt_r   <= 1'b1;
            pulse_cnt_r <= {PW{1'b0}};
            cnt_r       <= load_r;
            presc_cnt_r <= {PRESC_W{1'b0}};
            state_r     <= en_nxt_s ? RUN : IDLE;
          end else begin
            rst_wdt_r   <= 1'b0;
            pulse_cnt_r <= pulse_cnt_r + PW'(1);
            cnt_r       <= cnt_r;
            presc_cnt_r <= presc_cnt_r;
            state_r     <= BITE;
          end
        end

        default: begin
          state_r     <= IDLE;
          cnt_r       <= load_r;
          presc_cnt_r <= {PRESC_W{1'b0}};
          pulse_cnt_r <= {PW{1'b0}};
          rst_wdt_r   <= 1'b1;
        end
      endcase
    end
  end

  assign o_irq     = irq_r;
  assign o_rst_wdt = rst_wdt_r;

endmodule
